// File: rtl/idle_pm_pkg.sv
// Shared power-management types for the per-peripheral sleep controller.
package idle_pm_pkg;

    localparam int PWR_STATE_W = 2;

    typedef enum logic [PWR_STATE_W-1:0] {
        PWR_ACTIVE   = 2'd0,
        PWR_ENTERING = 2'd1,
        PWR_ASLEEP   = 2'd2,
        PWR_EXITING  = 2'd3
    } pwr_state_e;

    // sleep_req is held high in every state that owns the handshake toward sleep
    function automatic logic state_requests_sleep(input pwr_state_e st);
        return (st == PWR_ENTERING) || (st == PWR_ASLEEP);
    endfunction

endpackage

// File: rtl/periph_sleep_fsm.sv
// Single-peripheral power sequencer: idle counter, recent-activity window,
// wake latch and the ACTIVE/ENTERING/ASLEEP/EXITING handshake FSM.
module periph_sleep_fsm
    import idle_pm_pkg::*;
#(
    parameter int W       = 16,
    parameter int ACT_WIN = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   periph_busy,
    input  logic                   wake_req,
    input  logic                   sleep_eligible,
    input  logic                   sleep_ack,
    output logic [W-1:0]           idle_count,
    output logic                   recent_activity,
    output logic                   sleep_req,
    output logic [PWR_STATE_W-1:0] pwr_state
);

    localparam int           WIN_W    = $clog2(ACT_WIN + 1);
    localparam logic [W-1:0] IDLE_MAX = {W{1'b1}};
    localparam logic [W-1:0] IDLE_MIN = W'(2);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(ACT_WIN);

    pwr_state_e       state_r;
    pwr_state_e       state_nxt_s;
    logic             wake_pend_r;
    logic             wake_pend_nxt_s;
    logic [W-1:0]     idle_cnt_r;
    logic [W-1:0]     idle_cnt_nxt_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_cnt_nxt_s;
    logic             sleep_req_r;
    logic             recent_r;
    logic             wake_now_s;
    logic             enter_ok_s;
    logic             exit_done_s;

    // Next-state decode; wake sources always override entry into sleep
    always_comb begin
        state_nxt_s     = state_r;
        wake_pend_nxt_s = 1'b0;
        exit_done_s     = 1'b0;
        wake_now_s      = wake_req | periph_busy | ~en;
        // idle_count >= 2 masks an eligible result computed before the last busy cycle
        enter_ok_s      = en & sleep_eligible & ~periph_busy & ~wake_req &
                          (idle_cnt_r >= IDLE_MIN);
        case (state_r)
            PWR_ACTIVE: begin
                if (enter_ok_s) begin
                    state_nxt_s = PWR_ENTERING;
                end else begin
                    state_nxt_s = PWR_ACTIVE;
                end
            end
            PWR_ENTERING: begin
                if (sleep_ack) begin
                    // a wake seen now or earlier in ENTERING turns the ack into an exit
                    if (wake_pend_r | wake_now_s) begin
                        state_nxt_s = PWR_EXITING;
                    end else begin
                        state_nxt_s = PWR_ASLEEP;
                    end
                    wake_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = PWR_ENTERING;
                    wake_pend_nxt_s = wake_pend_r | wake_now_s;
                end
            end
            PWR_ASLEEP: begin
                if (wake_req | ~en) begin
                    state_nxt_s = PWR_EXITING;
                end else begin
                    state_nxt_s = PWR_ASLEEP;
                end
            end
            PWR_EXITING: begin
                if (!sleep_ack) begin
                    state_nxt_s = PWR_ACTIVE;
                    exit_done_s = 1'b1;
                end else begin
                    state_nxt_s = PWR_EXITING;
                end
            end
            default: begin
                state_nxt_s = PWR_ACTIVE;
            end
        endcase
    end

    // Idle counter: counts only in ACTIVE, frozen while sleeping, cleared on wake-up
    always_comb begin
        idle_cnt_nxt_s = idle_cnt_r;
        case (state_r)
            PWR_ACTIVE: begin
                if (periph_busy | wake_req) begin
                    idle_cnt_nxt_s = '0;
                end else if (idle_cnt_r != IDLE_MAX) begin
                    idle_cnt_nxt_s = idle_cnt_r + W'(1);
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r;
                end
            end
            PWR_EXITING: begin
                if (exit_done_s) begin
                    idle_cnt_nxt_s = '0;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r;
                end
            end
            default: begin
                idle_cnt_nxt_s = idle_cnt_r;
            end
        endcase
    end

    // Activity window: reload on any activity or wake-up, otherwise run down to zero
    always_comb begin
        win_cnt_nxt_s = win_cnt_r;
        if (periph_busy | wake_req | exit_done_s) begin
            win_cnt_nxt_s = WIN_LOAD;
        end else if (win_cnt_r != '0) begin
            win_cnt_nxt_s = win_cnt_r - WIN_W'(1);
        end else begin
            win_cnt_nxt_s = win_cnt_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PWR_ACTIVE;
            wake_pend_r <= 1'b0;
            idle_cnt_r  <= '0;
            win_cnt_r   <= '0;
            sleep_req_r <= 1'b0;
            recent_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wake_pend_r <= wake_pend_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
            win_cnt_r   <= win_cnt_nxt_s;
            sleep_req_r <= state_requests_sleep(state_nxt_s);
            recent_r    <= (win_cnt_nxt_s != '0);
        end
    end

    assign idle_count      = idle_cnt_r;
    assign recent_activity = recent_r;
    assign sleep_req       = sleep_req_r;
    assign pwr_state       = state_r;

endmodule

// File: rtl/periph_sleep_ctrl.sv
// Power-state controller for N independent peripherals; one sequencer each.
module periph_sleep_ctrl
    import idle_pm_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int ACT_WIN = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [N-1:0]                      periph_busy,
    input  logic [N-1:0]                      wake_req,
    input  logic [N-1:0]                      sleep_eligible,
    input  logic [N-1:0]                      sleep_ack,
    output logic [N-1:0][W-1:0]               idle_count,
    output logic [N-1:0]                      recent_activity,
    output logic [N-1:0]                      sleep_req,
    output logic [N-1:0][PWR_STATE_W-1:0]     pwr_state
);

    for (genvar gi = 0; gi < N; gi++) begin : g_periph
        periph_sleep_fsm #(
            .W       (W),
            .ACT_WIN (ACT_WIN)
        ) u_fsm (
            .clk             (clk),
            .rst             (rst),
            .en              (en),
            .periph_busy     (periph_busy[gi]),
            .wake_req        (wake_req[gi]),
            .sleep_eligible  (sleep_eligible[gi]),
            .sleep_ack       (sleep_ack[gi]),
            .idle_count      (idle_count[gi]),
            .recent_activity (recent_activity[gi]),
            .sleep_req       (sleep_req[gi]),
            .pwr_state       (pwr_state[gi])
        );
    end

endmodule

// File: tb/tb_periph_sleep_ctrl.sv
// Directed bench for periph_sleep_ctrl with N=4, W=4, ACT_WIN=8.
module tb_periph_sleep_ctrl;

    localparam int N       = 4;
    localparam int W       = 4;
    localparam int ACT_WIN = 8;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [N-1:0]          periph_busy;
    logic [N-1:0]          wake_req;
    logic [N-1:0]          sleep_eligible;
    logic [N-1:0]          sleep_ack;
    logic [N-1:0][W-1:0]   idle_count;
    logic [N-1:0]          recent_activity;
    logic [N-1:0]          sleep_req;
    logic [N-1:0][1:0]     pwr_state;

    int checks_r   = 0;
    int failures_r = 0;
    int act_cnt;

    periph_sleep_ctrl #(
        .N       (N),
        .W       (W),
        .ACT_WIN (ACT_WIN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .periph_busy     (periph_busy),
        .wake_req        (wake_req),
        .sleep_eligible  (sleep_eligible),
        .sleep_ack       (sleep_ack),
        .idle_count      (idle_count),
        .recent_activity (recent_activity),
        .sleep_req       (sleep_req),
        .pwr_state       (pwr_state)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1 unit after it
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst            = 1'b1;
        en             = 1'b0;
        periph_busy    = 4'b0000;
        wake_req       = 4'b0000;
        sleep_eligible = 4'b0000;
        sleep_ack      = 4'b0000;
        tick(2);
        check_eq("rst_idle",   32'(idle_count),      32'd0);
        check_eq("rst_recent", 32'(recent_activity), 32'd0);
        check_eq("rst_req",    32'(sleep_req),       32'd0);
        check_eq("rst_state",  32'(pwr_state),       32'd0);

        // 10 idle cycles
        rst = 1'b0;
        en  = 1'b1;
        tick(10);
        check_eq("idle10_cnt",    32'(idle_count[0]),      32'd10);
        check_eq("idle10_recent", 32'(recent_activity[0]), 32'd0);
        check_eq("idle10_state",  32'(pwr_state[0]),       32'd0);

        // single busy cycle: window high for ACT_WIN cycles, counter restarts
        periph_busy = 4'b0001;
        tick();
        periph_busy = 4'b0000;
        check_eq("busy_idle0", 32'(idle_count[0]), 32'd0);
        act_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (recent_activity[0]) act_cnt++;
            tick();
        end
        check_eq("win_len",    32'(act_cnt),            32'd8);
        check_eq("win_idle12", 32'(idle_count[0]),      32'd12);
        check_eq("win_p1",     32'(recent_activity[1]), 32'd0);

        // saturation at 15
        tick(3);
        check_eq("sat15",      32'(idle_count[0]), 32'd15);
        tick(2);
        check_eq("sat_hold",   32'(idle_count[0]), 32'd15);

        // busy together with eligible: busy wins
        periph_busy    = 4'b0001;
        sleep_eligible = 4'b0001;
        tick();
        check_eq("busy_elig_req",  32'(sleep_req[0]),  32'd0);
        check_eq("busy_elig_idle", 32'(idle_count[0]), 32'd0);
        periph_busy = 4'b0000;
        tick();
        // eligible sampled with idle_count=1: must not request
        tick();
        check_eq("elig_idle1_req", 32'(sleep_req[0]),  32'd0);
        check_eq("elig_idle1_cnt", 32'(idle_count[0]), 32'd2);
        sleep_eligible = 4'b0000;
        tick(3);
        check_eq("pre_enter_idle", 32'(idle_count[0]), 32'd5);

        // full cycle: enter at idle_count=5
        sleep_eligible = 4'b0001;
        tick();
        sleep_eligible = 4'b0000;
        check_eq("enter_req",   32'(sleep_req[0]), 32'd1);
        check_eq("enter_state", 32'(pwr_state[0]), 32'd1);
        tick(2);
        check_eq("wait_ack_state", 32'(pwr_state[0]), 32'd1);
        check_eq("wait_ack_req",   32'(sleep_req[0]), 32'd1);
        sleep_ack = 4'b0001;
        tick();
        check_eq("asleep_state", 32'(pwr_state[0]), 32'd2);
        check_eq("asleep_req",   32'(sleep_req[0]), 32'd1);
        tick();
        check_eq("asleep_hold",   32'(pwr_state[0]),  32'd2);
        check_eq("asleep_frozen", 32'(idle_count[0]), 32'd6);
        wake_req = 4'b0001;
        tick();
        wake_req = 4'b0000;
        check_eq("wake_req_drop", 32'(sleep_req[0]), 32'd0);
        check_eq("wake_exiting",  32'(pwr_state[0]), 32'd3);
        tick();
        check_eq("exit_hold", 32'(pwr_state[0]), 32'd3);
        sleep_ack = 4'b0000;
        tick();
        check_eq("back_active", 32'(pwr_state[0]),       32'd0);
        check_eq("back_idle",   32'(idle_count[0]),      32'd0);
        check_eq("back_recent", 32'(recent_activity[0]), 32'd1);

        // wake during ENTERING: ack leads straight to EXITING
        tick(2);
        sleep_eligible = 4'b0001;
        tick();
        sleep_eligible = 4'b0000;
        check_eq("ent2_state", 32'(pwr_state[0]), 32'd1);
        wake_req = 4'b0001;
        tick();
        wake_req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            check_eq("ent2_hold", 32'(pwr_state[0]), 32'd1);
            tick();
        end
        sleep_ack = 4'b0001;
        tick();
        check_eq("ent2_exit_state", 32'(pwr_state[0]), 32'd3);
        check_eq("ent2_exit_req",   32'(sleep_req[0]), 32'd0);
        sleep_ack = 4'b0000;
        tick();
        check_eq("ent2_active", 32'(pwr_state[0]), 32'd0);

        // reset while peripheral 1 is asleep with ack held
        sleep_eligible = 4'b0010;
        tick();
        sleep_eligible = 4'b0000;
        sleep_ack      = 4'b0010;
        tick();
        check_eq("p1_asleep",  32'(pwr_state[1]), 32'd2);
        check_eq("p1_req",     32'(sleep_req[1]), 32'd1);
        check_eq("p0_indep",   32'(pwr_state[0]), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("rst2_idle",   32'(idle_count),      32'd0);
        check_eq("rst2_recent", 32'(recent_activity), 32'd0);
        check_eq("rst2_req",    32'(sleep_req),       32'd0);
        check_eq("rst2_state",  32'(pwr_state),       32'd0);
        rst       = 1'b0;
        sleep_ack = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
